// File: rtl/serial_pattern_tx.sv
// Purpose: LSB-first parallel-to-serial framer, one pending word, optional idle gap after each frame.
// Latency: bit 0 of a word accepted in IDLE appears on sout_o the cycle after acceptance.
// Backpressure: ready_o is low while the pending register is full; it comes only from registered state.
// Ports: clk, rst (synchronous, active-high).
//        pin_i/len_i/valid_i/ready_o form the word handshake. len_i of 0, or above DWIDTH, means DWIDTH.
//        sout_o/sval_o carry the serial bit and its qualifier. busy_o shows that a frame or gap is active.
//        done_o marks the last bit of each frame.
module serial_pattern_tx #(
  parameter int DWIDTH     = 32,
  parameter int GAP_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DWIDTH-1:0]       pin_i,
  input  logic [$clog2(DWIDTH):0] len_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    sout_o,
  output logic                    sval_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int LW         = $clog2(DWIDTH) + 1;
  localparam int GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);
  localparam logic [LW-1:0] DW_L     = LW'(DWIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] sh_q, sh_d;          // bits still to send after the one on sout_o
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     cnt_q, cnt_d;        // index of the bit currently on sout_o
  logic [GW-1:0]     gap_q, gap_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DWIDTH-1:0] pend_dat_q, pend_dat_d;
  logic [LW-1:0]     pend_len_q, pend_len_d;
  logic              sout_q, sout_d;
  logic              sval_q, sval_d;
  logic              done_q, done_d;

  logic              accept;
  logic              frame_end;
  logic              load;
  logic [DWIDTH-1:0] load_dat;
  logic [LW-1:0]     load_len;
  logic [LW-1:0]     cnt_inc;
  logic [LW-1:0]     len_last;

  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
    if (l == '0 || l > DW_L) return DW_L;
    return l;
  endfunction

  assign accept   = valid_i && !pend_vld_q;
  assign cnt_inc  = cnt_q + 1'b1;
  assign len_last = len_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    pend_len_d = pend_len_q;
    sout_d     = 1'b0;
    sval_d     = 1'b0;
    done_d     = 1'b0;
    frame_end  = 1'b0;
    load       = 1'b0;
    load_dat   = pin_i;
    load_len   = eff_len(len_i);

    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == len_last) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          cnt_d  = cnt_inc;
          sh_d   = sh_q >> 1;
          sout_d = sh_q[0];
          sval_d = 1'b1;
          done_d = (cnt_inc == len_last);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) frame_end = 1'b1;
        else                   gap_d     = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // At a frame boundary the pending word goes first. If the pending register is
    // empty, a word accepted on this same edge goes straight to the shifter, so the
    // stream stays contiguous and no bubble is spent passing it through pending.
    if (frame_end) begin
      if (pend_vld_q) begin
        load       = 1'b1;
        load_dat   = pend_dat_q;
        load_len   = pend_len_q;
        pend_vld_d = 1'b0;
      end else if (accept) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else if (accept && state_q != IDLE) begin
      pend_vld_d = 1'b1;
      pend_dat_d = pin_i;
      pend_len_d = eff_len(len_i);
    end

    if (load) begin
      state_d = SHIFT;
      sh_d    = load_dat >> 1;
      len_d   = load_len;
      cnt_d   = '0;
      sout_d  = load_dat[0];
      sval_d  = 1'b1;
      done_d  = (load_len == LW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      pend_len_q <= '0;
      sout_q     <= 1'b0;
      sval_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      pend_len_q <= pend_len_d;
      sout_q     <= sout_d;
      sval_q     <= sval_d;
      done_q     <= done_d;
    end
  end

  assign ready_o = !pend_vld_q;
  assign busy_o  = (state_q != IDLE);
  assign sout_o  = sout_q;
  assign sval_o  = sval_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx. One instance runs back-to-back frames; a second instance
// runs with a three-cycle gap between frames. Expected bit streams are built from word
// and length values using plain arithmetic and queues.
module tb_serial_pattern_tx;
  localparam int DW  = 32;
  localparam int LW  = $clog2(DW) + 1;
  localparam int GAP = 3;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic          rst;
  logic [DW-1:0] pin;
  logic [LW-1:0] len;
  logic          valid, ready, sout, sval, busy, done;
  logic [DW-1:0] g_pin;
  logic [LW-1:0] g_len;
  logic          g_valid, g_ready, g_sout, g_sval, g_busy, g_done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_pattern_tx #(.DWIDTH(DW), .GAP_CYCLES(0)) dut (
    .clk(tb_clk), .rst(rst), .pin_i(pin), .len_i(len), .valid_i(valid),
    .ready_o(ready), .sout_o(sout), .sval_o(sval), .busy_o(busy), .done_o(done));

  serial_pattern_tx #(.DWIDTH(DW), .GAP_CYCLES(GAP)) dut_g (
    .clk(tb_clk), .rst(rst), .pin_i(g_pin), .len_i(g_len), .valid_i(g_valid),
    .ready_o(g_ready), .sout_o(g_sout), .sval_o(g_sval), .busy_o(g_busy), .done_o(g_done));

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > DW) ? DW : l;
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; pin = $urandom; len = '0;
    g_valid = 1'b1; g_pin = $urandom; g_len = '0;
    tick(); tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (sval  !== 1'b0) begin n_fail++; $display("FAIL reset_sval got %b want 0", sval); end
    n_checks++; if (sout  !== 1'b0) begin n_fail++; $display("FAIL reset_sout got %b want 0", sout); end
    n_checks++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done  !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (g_busy !== 1'b0) begin n_fail++; $display("FAIL reset_gbusy got %b want 0", g_busy); end
    n_checks++; if (g_ready !== 1'b1) begin n_fail++; $display("FAIL reset_gready got %b want 1", g_ready); end
    valid = 1'b0; g_valid = 1'b0; rst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_noaccept got busy %b want 0", busy); end
  endtask

  task automatic test_long_frame();
    logic [DW-1:0] w;
    w = 32'hFDCA5398;
    pin = w; len = '0; valid = 1'b1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL long_ready got %b want 1", ready); end
    tick();
    valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_checks++; if (sval !== 1'b1) begin n_fail++; $display("FAIL long_sval k=%0d got %b want 1", k, sval); end
      n_checks++; if (sout !== w[k]) begin n_fail++; $display("FAIL long_sout k=%0d got %b want %b", k, sout, w[k]); end
      n_checks++; if (done !== (k == 31)) begin n_fail++; $display("FAIL long_done k=%0d got %b want %b", k, done, (k == 31)); end
      tick();
    end
    n_checks++; if (sval !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL long_end got sval %b busy %b done %b want 0 0 0", sval, busy, done); end
  endtask

  task automatic test_short_frame();
    logic [DW-1:0] w;
    w = 32'h0000000A;
    pin = w; len = LW'(4); valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (sval !== 1'b1 || sout !== w[k]) begin
        n_fail++; $display("FAIL short_bit k=%0d got sval %b sout %b want 1 %b", k, sval, sout, w[k]); end
      n_checks++; if (done !== (k == 3)) begin n_fail++; $display("FAIL short_done k=%0d got %b want %b", k, done, (k == 3)); end
      tick();
    end
    n_checks++; if (busy !== 1'b0 || sval !== 1'b0) begin
      n_fail++; $display("FAIL short_idle got busy %b sval %b want 0 0", busy, sval); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    logic          eb, er;
    a = 32'h000000F0; b = 32'h0000000F;
    pin = a; len = LW'(8); valid = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) pin = b;
      if (c == 2) valid = 1'b0;
      eb = (c <= 8) ? a[c-1] : b[c-9];
      er = (c == 1 || c >= 9);
      n_checks++; if (sval !== 1'b1 || sout !== eb) begin
        n_fail++; $display("FAIL b2b_bit c=%0d got sval %b sout %b want 1 %b", c, sval, sout, eb); end
      n_checks++; if (done !== (c == 8 || c == 16)) begin
        n_fail++; $display("FAIL b2b_done c=%0d got %b want %b", c, done, (c == 8 || c == 16)); end
      n_checks++; if (ready !== er) begin n_fail++; $display("FAIL b2b_ready c=%0d got %b want %b", c, ready, er); end
      tick();
    end
    n_checks++; if (busy !== 1'b0 || sval !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got busy %b sval %b want 0 0", busy, sval); end
  endtask

  task automatic test_gap();
    logic [DW-1:0] a, b;
    logic          es, eb, er;
    a = 32'h9; b = 32'h6;
    g_pin = a; g_len = LW'(4); g_valid = 1'b1;
    tick();
    for (int c = 1; c <= 4 + GAP + 4; c++) begin
      if (c == 1) g_pin = b;
      if (c == 2) g_valid = 1'b0;
      es = (c <= 4) || (c > 4 + GAP);
      eb = (c <= 4) ? a[c-1] : (c > 4 + GAP) ? b[c-5-GAP] : 1'b0;
      er = (c == 1) || (c > 4 + GAP);
      n_checks++; if (g_sval !== es || g_sout !== eb) begin
        n_fail++; $display("FAIL gap_bit c=%0d got sval %b sout %b want %b %b", c, g_sval, g_sout, es, eb); end
      n_checks++; if (g_done !== (c == 4 || c == 8 + GAP)) begin
        n_fail++; $display("FAIL gap_done c=%0d got %b want %b", c, g_done, (c == 4 || c == 8 + GAP)); end
      n_checks++; if (g_busy !== 1'b1 || g_ready !== er) begin
        n_fail++; $display("FAIL gap_busy_ready c=%0d got %b %b want 1 %b", c, g_busy, g_ready, er); end
      tick();
    end
    // The last frame is also followed by a full gap before the block goes idle.
    for (int c = 0; c < GAP; c++) begin
      n_checks++; if (g_busy !== 1'b1 || g_sval !== 1'b0) begin
        n_fail++; $display("FAIL gap_tail c=%0d got busy %b sval %b want 1 0", c, g_busy, g_sval); end
      tick();
    end
    n_checks++; if (g_busy !== 1'b0) begin n_fail++; $display("FAIL gap_idle got busy %b want 0", g_busy); end
  endtask

  task automatic test_hold_valid();
    logic [DW-1:0] wd [3];
    int            wl [3];
    int            acc [3];
    logic          exp_bits [$];
    logic          exp_done [$];
    logic          obs_bits [$];
    logic          obs_done [$];
    int            idx, first, last;
    logic          accepted, finished;
    wl[0] = 5; wl[1] = 6; wl[2] = 3;
    for (int i = 0; i < 3; i++) begin
      wd[i] = $urandom;
      for (int k = 0; k < wl[i]; k++) begin
        exp_bits.push_back(wd[i][k]);
        exp_done.push_back(k == wl[i] - 1);
      end
    end
    idx = 0; first = -1; last = -1; finished = 1'b0;
    pin = wd[0]; len = LW'(wl[0]); valid = 1'b1;
    for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
      if (cyc > 0 && sval) begin
        obs_bits.push_back(sout); obs_done.push_back(done);
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (idx == 3 && cyc > 0 && !busy) begin
        finished = 1'b1;
      end else begin
        accepted = valid && ready;
        if (accepted) acc[idx] = cyc;
        tick();
        if (accepted) begin
          idx++;
          if (idx < 3) begin pin = wd[idx]; len = LW'(wl[idx]); end
          else valid = 1'b0;
        end
      end
    end
    valid = 1'b0;
    n_checks++; if (!finished) begin n_fail++; $display("FAIL hold_timeout got idx %0d want 3 and idle", idx); end
    n_checks++; if (idx != 3 || acc[0] != 0 || acc[1] != 1 || acc[2] != 6) begin
      n_fail++; $display("FAIL hold_accept_cycles got %0d %0d %0d want 0 1 6", acc[0], acc[1], acc[2]); end
    n_checks++; if (obs_bits.size() != exp_bits.size() || last - first + 1 != exp_bits.size()) begin
      n_fail++; $display("FAIL hold_len got %0d bits span %0d want %0d", obs_bits.size(), last - first + 1, exp_bits.size()); end
    else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        n_checks++; if (obs_bits[i] !== exp_bits[i] || obs_done[i] !== exp_done[i]) begin
          n_fail++; $display("FAIL hold_bit i=%0d got %b/%b want %b/%b", i, obs_bits[i], obs_done[i], exp_bits[i], exp_done[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] w1, w4;
    w1 = $urandom; w4 = $urandom;
    pin = w1; len = '0; valid = 1'b1;
    tick();
    pin = $urandom;
    tick();
    valid = 1'b0;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending got ready %b want 0", ready); end
    for (int k = 1; k < 10; k++) tick();
    n_checks++; if (sval !== 1'b1 || sout !== w1[10]) begin
      n_fail++; $display("FAIL rstmid_bit10 got sval %b sout %b want 1 %b", sval, sout, w1[10]); end
    rst = 1'b1; valid = 1'b1; pin = $urandom;
    tick();
    n_checks++; if (sval !== 1'b0 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_idle got sval %b sout %b busy %b done %b ready %b want 0 0 0 0 1",
                          sval, sout, busy, done, ready); end
    rst = 1'b0; valid = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after got busy %b done %b want 0 0", busy, done); end
    pin = w4; len = LW'(8); valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (sval !== 1'b1 || sout !== w4[k] || done !== (k == 7)) begin
        n_fail++; $display("FAIL rstmid_new k=%0d got %b %b %b want 1 %b %b", k, sval, sout, done, w4[k], (k == 7)); end
      tick();
    end
    n_checks++; if (sval !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_nostale got sval %b busy %b want 0 0", sval, busy); end
  endtask

  task automatic test_random();
    logic exp_bits [$];
    logic exp_done [$];
    logic eb, ed;
    int   l, drain;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++; if (sval !== (exp_bits.size() > 0)) begin
        n_fail++; $display("FAIL rand_sval cyc=%0d got %b want %b", cyc, sval, (exp_bits.size() > 0)); end
      if (sval && exp_bits.size() > 0) begin
        eb = exp_bits.pop_front(); ed = exp_done.pop_front();
        n_checks++; if (sout !== eb || done !== ed) begin
          n_fail++; $display("FAIL rand_bit cyc=%0d got %b/%b want %b/%b", cyc, sout, done, eb, ed); end
      end else begin
        n_checks++; if (sout !== 1'b0 || done !== 1'b0) begin
          n_fail++; $display("FAIL rand_quiet cyc=%0d got %b/%b want 0/0", cyc, sout, done); end
      end
      valid = ($urandom_range(0, 3) != 0);
      pin = $urandom;
      len = ($urandom_range(0, 1) != 0) ? LW'($urandom_range(1, 6)) : LW'($urandom_range(0, 2**LW - 1));
      if (valid && ready) begin
        l = eff_len(int'(len));
        for (int k = 0; k < l; k++) begin
          exp_bits.push_back(pin[k]);
          exp_done.push_back(k == l - 1);
        end
      end
      tick();
    end
    valid = 1'b0;
    drain = 0;
    while ((exp_bits.size() > 0 || busy) && drain < 300) begin
      if (sval && exp_bits.size() > 0) begin
        eb = exp_bits.pop_front(); ed = exp_done.pop_front();
        n_checks++; if (sout !== eb || done !== ed) begin
          n_fail++; $display("FAIL rand_drain d=%0d got %b/%b want %b/%b", drain, sout, done, eb, ed); end
      end
      tick();
      drain++;
    end
    n_checks++; if (exp_bits.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rand_drain_end got %0d bits left busy %b want 0 0", exp_bits.size(), busy); end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; pin = '0; len = '0;
    g_valid = 1'b0; g_pin = '0; g_len = '0;
    test_reset();
    test_long_frame();
    test_short_frame();
    test_back_to_back();
    test_gap();
    test_hold_valid();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
